code_lock_ctrl: RTL and testbench
=================================

Name: code_lock_ctrl

Overview:
- Downstream consumer of the 1-0-9-4 sequence detector's one-cycle `match` output, plus a digit strobe from the keypad front end.
- Converts matches into a timed unlock window.
- Counts failed attempts, where an attempt is DIGITS_PER_TRY digits with no match. Enforces a timed lockout after MAX_FAILS failures.
- Drives the door actuator enable and the alarm indicator.

Parameters:
- DIGITS_PER_TRY, 4: digits per attempt; range 1..15.
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout; range 1..7.
- UNLOCK_CYCLES, 50000: clock cycles the unlock window lasts; range 1..65535.
- LOCKOUT_CYCLES, 60000: clock cycles the lockout lasts; range 1..65535.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- digit_strobe  in  1  one-cycle pulse: a digit is on the detector input this cycle.
- match  in  1  detector output; high exactly one cycle after the final '4' strobe.
- clear  in  1  user abort / relock, single-cycle pulse.
- unlocked  out  1  registered; high during the unlock window.
- locked_out  out  1  registered; high during lockout.
- alarm  out  1  registered; one-cycle pulse on entry to LOCKOUT.
- fail_count  out  3  registered count of consecutive failed attempts.

Behaviour:
- Reset (async assert, sync release):
  - state=LOCKED, digit_cnt=0, eval_pending=0, timer=0.
  - unlocked=0, locked_out=0, alarm=0, fail_count=0.
- States:
  - LOCKED: accepting digits.
  - UNLOCKED: timer counting down.
  - LOCKOUT: timer counting down, all inputs ignored except rst.
- Per-cycle priority in LOCKED: match > clear > eval_pending > digit_strobe.
- LOCKED, match=1:
  - Go to UNLOCKED; timer=UNLOCK_CYCLES-1.
  - digit_cnt=0, eval_pending=0, fail_count=0.
  - unlocked=1 from the next cycle.
  - Any match in LOCKED unlocks, including mid-attempt; the detector is sliding.
- LOCKED, clear=1: digit_cnt=0, eval_pending=0; fail_count unchanged.
- LOCKED, digit_strobe=1:
  - digit_cnt++.
  - If the increment reaches DIGITS_PER_TRY: digit_cnt=0, eval_pending=1. The attempt is judged one cycle later, because match lags the strobe by one cycle.
- LOCKED, eval_pending=1 and match=0 (failure):
  - eval_pending=0.
  - If fail_count+1 == MAX_FAILS: go to LOCKOUT; timer=LOCKOUT_CYCLES-1; alarm=1 for one cycle; fail_count=MAX_FAILS (held during lockout).
  - Else fail_count++.
  - A digit_strobe in the same cycle is still counted: digit_cnt=1.
- UNLOCKED:
  - unlocked=1; timer decrements each cycle. The window is exactly UNLOCK_CYCLES cycles of unlocked=1.
  - When timer==0: go to LOCKED.
  - clear=1: immediate LOCKED; unlocked=0 next cycle.
  - match=1: reload timer=UNLOCK_CYCLES-1 (window extended).
  - Digit strobes are ignored; digit_cnt stays 0.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYCLES cycles.
  - At timer==0: go to LOCKED; fail_count=0; digit_cnt=0.
  - match, clear and digit_strobe are ignored.
- Registered-output timing: outputs change in the cycle after the causing event. alarm is never high for 2 consecutive cycles.
- Widths:
  - timer: 16-bit, never wraps; it is reloaded on state entry.
  - digit_cnt: 4-bit.
  - fail_count: saturates at MAX_FAILS.
- Reset asserted mid-window or mid-lockout: all state clears immediately; no alarm pulse is generated.

Decomposition:
- Shared package lock_pkg holds:
  - the state encoding (LOCKED=2'b00, UNLOCKED=2'b01, LOCKOUT=2'b10);
  - default parameter constants;
  - TIMER_W=16.
- One natural sub-module, lock_timer: 16-bit loadable down-counter with load, load_value, enable and a zero flag. It is shared by the UNLOCKED and LOCKOUT states.
- Everything else stays in code_lock_ctrl.

Test Plan (bench overrides: UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, DIGITS_PER_TRY=4, MAX_FAILS=3):
- Correct code: strobes for 1,0,9,4 with match 1 cycle after the 4th strobe -> unlocked high for exactly 8 cycles starting the cycle after match; fail_count=0.
- Three wrong 4-digit attempts (no match) -> fail_count goes 1, 2. On the 3rd evaluation: alarm high 1 cycle, locked_out high exactly 16 cycles, then fail_count=0.
- During lockout: a match pulse plus 4 strobes -> no change; locked_out still high; unlocked stays 0.
- Unlocked, clear at window cycle 3 -> unlocked=0 next cycle. Separately, a match at cycle 5 -> the window extends to 8 cycles from that match.
- Simultaneous: eval_pending failure and digit_strobe in the same cycle -> fail_count+1 and digit_cnt=1. Then 3 more strobes -> a second evaluation occurs.
- rst asserted asynchronously mid-lockout (off clock edge) -> locked_out, fail_count and alarm go to 0 immediately. After release, a correct code unlocks normally.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and constants for the code lock controller and its timer.
`timescale 1ns/1ps
package lock_pkg;

  localparam int TIMER_W = 16;

  localparam int DEF_DIGITS_PER_TRY = 4;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_UNLOCK_CYCLES  = 50000;
  localparam int DEF_LOCKOUT_CYCLES = 60000;

  typedef enum logic [1:0] {
    LOCKED   = 2'b00,
    UNLOCKED = 2'b01,
    LOCKOUT  = 2'b10
  } state_e;

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Keypad/detector inputs and lock status outputs of the code lock controller.
`timescale 1ns/1ps
interface code_lock_ctrl_if;

  logic       digit_strobe;
  logic       match;
  logic       clear;
  logic       unlocked;
  logic       locked_out;
  logic       alarm;
  logic [2:0] fail_count;

  modport master (
    output digit_strobe, match, clear,
    input  unlocked, locked_out, alarm, fail_count
  );

  modport slave (
    input  digit_strobe, match, clear,
    output unlocked, locked_out, alarm, fail_count
  );

endinterface

// File: rtl/lock_timer.sv
// Loadable 16-bit down-counter that stops at zero; shared by unlock window and lockout.
`timescale 1ns/1ps
module lock_timer
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_value_i,
  input  logic               enable_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Turns detector matches into a timed unlock window and enforces a timed
// lockout after too many consecutive failed attempts.
`timescale 1ns/1ps
module code_lock_ctrl
  import lock_pkg::*;
#(
  parameter int DIGITS_PER_TRY = DEF_DIGITS_PER_TRY,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  code_lock_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [3:0]         digit_cnt_q, digit_cnt_d;
  logic               eval_pending_q, eval_pending_d;
  logic [2:0]         fail_count_q, fail_count_d;
  logic               unlocked_q, unlocked_d;
  logic               locked_out_q, locked_out_d;
  logic               alarm_q, alarm_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_enable;
  logic               tmr_zero;

  logic [3:0]         digit_inc;
  logic               digit_wrap;

  assign digit_inc  = digit_cnt_q + 4'd1;
  assign digit_wrap = (digit_inc == 4'(DIGITS_PER_TRY));

  lock_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .enable_i     (tmr_enable),
    .zero_o       (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOCKED;
      digit_cnt_q    <= '0;
      eval_pending_q <= 1'b0;
      fail_count_q   <= '0;
      unlocked_q     <= 1'b0;
      locked_out_q   <= 1'b0;
      alarm_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      digit_cnt_q    <= digit_cnt_d;
      eval_pending_q <= eval_pending_d;
      fail_count_q   <= fail_count_d;
      unlocked_q     <= unlocked_d;
      locked_out_q   <= locked_out_d;
      alarm_q        <= alarm_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    digit_cnt_d    = digit_cnt_q;
    eval_pending_d = eval_pending_q;
    fail_count_d   = fail_count_q;
    alarm_d        = 1'b0;
    tmr_load       = 1'b0;
    tmr_value      = '0;
    tmr_enable     = 1'b0;

    unique case (state_q)
      LOCKED: begin
        if (bus.match) begin
          state_d        = UNLOCKED;
          tmr_load       = 1'b1;
          tmr_value      = TIMER_W'(UNLOCK_CYCLES - 1);
          digit_cnt_d    = '0;
          eval_pending_d = 1'b0;
          fail_count_d   = '0;
        end else if (bus.clear) begin
          digit_cnt_d    = '0;
          eval_pending_d = 1'b0;
        end else if (eval_pending_q && (fail_count_q + 3'd1 == 3'(MAX_FAILS))) begin
          state_d        = LOCKOUT;
          tmr_load       = 1'b1;
          tmr_value      = TIMER_W'(LOCKOUT_CYCLES - 1);
          alarm_d        = 1'b1;
          eval_pending_d = 1'b0;
          fail_count_d   = 3'(MAX_FAILS);
        end else begin
          // A non-fatal failure still lets a same-cycle strobe start the next
          // attempt; digit_cnt_q is already 0 whenever eval_pending_q is set.
          if (eval_pending_q) begin
            eval_pending_d = 1'b0;
            fail_count_d   = fail_count_q + 3'd1;
          end
          if (bus.digit_strobe) begin
            if (digit_wrap) begin
              digit_cnt_d    = '0;
              eval_pending_d = 1'b1;
            end else begin
              digit_cnt_d    = digit_inc;
            end
          end
        end
      end

      UNLOCKED: begin
        if (bus.clear) begin
          state_d   = LOCKED;
        end else if (bus.match) begin
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(UNLOCK_CYCLES - 1);
        end else if (tmr_zero) begin
          state_d   = LOCKED;
        end else begin
          tmr_enable = 1'b1;
        end
      end

      LOCKOUT: begin
        if (tmr_zero) begin
          state_d      = LOCKED;
          fail_count_d = '0;
          digit_cnt_d  = '0;
        end else begin
          tmr_enable   = 1'b1;
        end
      end

      default: begin
        state_d = LOCKED;
      end
    endcase

    unlocked_d   = (state_d == UNLOCKED);
    locked_out_d = (state_d == LOCKOUT);
  end

  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_out_q;
  assign bus.alarm      = alarm_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed, table-driven bench for code_lock_ctrl with short timer settings.
`timescale 1ns/1ps
module tb_code_lock_ctrl;

  logic clk;
  logic rst;

  code_lock_ctrl_if bus ();

  code_lock_ctrl #(
    .DIGITS_PER_TRY (4),
    .MAX_FAILS      (3),
    .UNLOCK_CYCLES  (8),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       m;
    logic       c;
    logic       exp_unl;
    logic       exp_lko;
    logic       exp_alm;
    logic [2:0] exp_fail;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void add(logic s, logic m, logic c, logic u, logic l, logic a, int f);
    vec_t v;
    v.s = s; v.m = m; v.c = c;
    v.exp_unl = u; v.exp_lko = l; v.exp_alm = a; v.exp_fail = 3'(f);
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic u, logic l, logic a, int f);
    chk({tag, ".unlocked"},   int'(bus.unlocked),   int'(u));
    chk({tag, ".locked_out"}, int'(bus.locked_out), int'(l));
    chk({tag, ".alarm"},      int'(bus.alarm),      int'(a));
    chk({tag, ".fail_count"}, int'(bus.fail_count), f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(logic s, logic m, logic c);
    bus.digit_strobe = s;
    bus.match        = m;
    bus.clear        = c;
    tick();
    bus.digit_strobe = 1'b0;
    bus.match        = 1'b0;
    bus.clear        = 1'b0;
  endtask

  task automatic enter_code();
    repeat (4) apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Correct code: window of 8 cycles after the match.
    repeat (4) add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);
    repeat (7) add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // Two failed attempts, then the third enters lockout.
    for (int k = 1; k <= 2; k++) begin
      repeat (4) add(1, 0, 0, 0, 0, 0, k - 1);
      add(0, 0, 0, 0, 0, 0, k);
    end
    repeat (4) add(1, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 1, 3);
    // Lockout: inputs are ignored, 15 further cycles of locked_out.
    for (int i = 0; i < 15; i++) begin
      add((i >= 3 && i <= 6) ? 1'b1 : 1'b0, (i == 2) ? 1'b1 : 1'b0,
          (i == 8) ? 1'b1 : 1'b0, 0, 1, 0, 3);
    end
    add(0, 0, 0, 0, 0, 0, 0);

    bus.digit_strobe = 1'b0;
    bus.match        = 1'b0;
    bus.clear        = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    chk_all("reset", 0, 0, 0, 0);
    #2 rst = 1'b0;
    tick();
    chk_all("post_reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].s, vecs[i].m, vecs[i].c);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_unl, vecs[i].exp_lko,
              vecs[i].exp_alm, int'(vecs[i].exp_fail));
      $display("vec %0d s=%0b m=%0b c=%0b -> unl=%0b lko=%0b alm=%0b fail=%0d", i,
               vecs[i].s, vecs[i].m, vecs[i].c, bus.unlocked, bus.locked_out,
               bus.alarm, bus.fail_count);
    end

    // Clear in window cycle 3 relocks on the next cycle.
    enter_code();
    chk("clr.cycle1", int'(bus.unlocked), 1);
    tick();
    tick();
    chk("clr.cycle3", int'(bus.unlocked), 1);
    apply(1'b0, 1'b0, 1'b1);
    chk("clr.after", int'(bus.unlocked), 0);
    tick();
    chk("clr.stays", int'(bus.unlocked), 0);
    $display("seq clear_in_window done");

    // Match in window cycle 5 restarts the 8-cycle window.
    enter_code();
    repeat (4) tick();
    chk("ext.cycle5", int'(bus.unlocked), 1);
    apply(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ext.win%0d", i), int'(bus.unlocked), 1);
      if (i < 7) tick();
    end
    tick();
    chk("ext.end", int'(bus.unlocked), 0);
    $display("seq window_extend done");

    // Failure evaluation coinciding with the first strobe of the next attempt.
    repeat (4) apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    chk("sim.fail1", int'(bus.fail_count), 1);
    repeat (3) apply(1'b1, 1'b0, 1'b0);
    chk("sim.pre", int'(bus.fail_count), 1);
    apply(1'b0, 1'b0, 1'b0);
    chk("sim.fail2", int'(bus.fail_count), 2);
    $display("seq simultaneous_eval done");

    // Asynchronous reset in the middle of lockout.
    repeat (4) apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0);
    chk_all("lk.entry", 0, 1, 1, 3);
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    chk_all("arst", 0, 0, 0, 0);
    #2 rst = 1'b0;
    tick();
    chk_all("arst.rel", 0, 0, 0, 0);
    enter_code();
    chk_all("arst.code", 1, 0, 0, 0);
    $display("seq async_reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
